// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Collects blocks of up to COUNT sums from an upstream N-bit adder and
//   presents each block's unsigned total and sample count with a
//   valid/ready handshake. A block closes when COUNT samples have been
//   accepted, or early on flush once it holds at least one sample.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_sum is valid this cycle
//   in_ready   block can accept a sample (state ACC)
//   in_sum     N+1 bit sample from the upstream adder
//   flush      close the current block early
//   out_valid  out_total/out_count are valid (state HOLD)
//   out_ready  downstream accepts the result
//   out_total  ACC_W bit unsigned block sum
//   out_count  number of samples in the block, 1..COUNT
module sum_accumulator #(
    parameter int N     = 3,
    parameter int COUNT = 4,
    localparam int ACC_W = N + 1 + $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [4:0]       out_count
);

    // Wide enough to hold COUNT itself.
    localparam int CNT_W = $clog2(COUNT) + 1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_sum;
    logic             close;

    // Values as they will be after this cycle's sample (if any) is taken in.
    assign accept  = (state == ACC) && in_valid;
    assign acc_sum = acc + (accept ? {{(ACC_W-N-1){1'b0}}, in_sum} : '0);
    assign cnt_sum = cnt + {{(CNT_W-1){1'b0}}, accept};

    // A flush on an empty block is ignored, but a flush that arrives with the
    // first sample still closes a one-sample block.
    assign close = (state == ACC) &&
                   ((accept && (cnt_sum == CNT_W'(COUNT))) ||
                    (flush && (cnt_sum != '0)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (close)     state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == HOLD);
    end

    // Datapath. acc/cnt are cleared when the block closes, so they are
    // already zero when HOLD hands back to ACC.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_total <= '0;
            out_count <= '0;
        end else if (state == ACC) begin
            if (close) begin
                out_total <= acc_sum;
                out_count <= 5'(cnt_sum);
                acc       <= '0;
                cnt       <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt_sum;
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    localparam int N     = 3;
    localparam int COUNT = 4;
    localparam int ACC_W = N + 1 + $clog2(COUNT);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N:0]       in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic [4:0]       out_count;

    int checks = 0;
    int errors = 0;

    sum_accumulator #(.N(N), .COUNT(COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the open block is a list of samples; a finished
    // block becomes a pending (total, count) result until taken downstream.
    int blk[$];
    bit m_hold  = 1'b0;
    int m_total = 0;
    int m_count = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            blk.delete();
            m_hold  = 1'b0;
            m_total = 0;
            m_count = 0;
        end else if (!m_hold) begin
            if (in_valid) blk.push_back(int'(in_sum));
            if (blk.size() == COUNT || (flush && blk.size() > 0)) begin
                m_total = 0;
                foreach (blk[i]) m_total += blk[i];
                m_count = blk.size();
                blk.delete();
                m_hold = 1'b1;
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
        end
    end

    // Results handed downstream, for the literal per-scenario checks.
    int res_t[$];
    int res_c[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", int'(in_ready), int'(!m_hold));
            chk("out_valid", int'(out_valid), int'(m_hold));
            if (m_hold) begin
                chk("out_total", int'(out_total), m_total);
                chk("out_count", int'(out_count), m_count);
            end
            if (out_valid && out_ready && !rst) begin
                res_t.push_back(int'(out_total));
                res_c.push_back(int'(out_count));
            end
        end
    end

    task automatic step(input bit v, input int s, input bit f, input bit r, input bit rs);
        in_valid  = v;
        in_sum    = (N+1)'(s);
        flush     = f;
        out_ready = r;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string nm, input int t, input int c);
        if (res_t.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s no result, expected total=%0d count=%0d", nm, t, c);
        end else begin
            chk({nm, "_total"}, res_t.pop_front(), t);
            chk({nm, "_count"}, res_c.pop_front(), c);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_sum    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(0, 0, 0, 0, 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_total", int'(out_total), 0);
        chk("rst_out_count", int'(out_count), 0);

        // 1,2,3,4 back to back
        step(1, 1, 0, 1, 0);
        step(1, 2, 0, 1, 0);
        step(1, 3, 0, 1, 0);
        step(1, 4, 0, 1, 0);
        chk("s1_valid_next_cycle", int'(out_valid), 1);
        chk("s1_total_lit", int'(out_total), 10);
        step(0, 0, 0, 1, 0);
        chk("s1_single_cycle", int'(out_valid), 0);
        expect_res("s1", 10, 4);

        // maximum values, no wrap
        for (int i = 0; i < 4; i++) step(1, 15, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_res("s2", 60, 4);

        // backpressure for 3 cycles; samples and flush in HOLD are ignored
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("s3_hold_valid", int'(out_valid), 1);
            chk("s3_hold_ready", int'(in_ready), 0);
            chk("s3_hold_total", int'(out_total), 4);
            if (i < 2) step(1, 7, 1, 0, 0);
        end
        chk("s3_no_res_yet", res_t.size(), 0);
        step(1, 9, 0, 1, 0);        // handshake cycle: sample not taken
        step(0, 0, 0, 1, 0);
        expect_res("s3", 4, 4);

        // flush after 5,6; then 7 and flush together with 8
        step(1, 5, 0, 1, 0);
        step(1, 6, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_res("s4a", 11, 2);
        step(1, 7, 0, 1, 0);
        step(1, 8, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_res("s4b", 15, 2);

        // reset mid-block discards the partial block
        step(1, 3, 0, 1, 0);
        step(1, 3, 0, 1, 0);
        step(1, 3, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("s5_nres", res_t.size(), 1);
        expect_res("s5", 4, 4);

        // reset while holding a result: no handshake
        for (int i = 0; i < 4; i++) step(1, 2, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("s5b_ready_after_rst", int'(in_ready), 1);
        chk("s5b_total_cleared", int'(out_total), 0);
        chk("s5b_nres", res_t.size(), 0);

        // idle flush, then 2s with gaps of 1, 3 and 0 cycles
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("s6_idle_flush", int'(out_valid), 0);
        step(1, 2, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(1, 2, 0, 1, 0);
        step(1, 2, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_res("s6", 8, 4);

        // flush on empty block together with a sample closes a 1-sample block
        step(1, 9, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_res("s7", 9, 1);

        step(0, 0, 0, 1, 0);
        chk("leftover_results", res_t.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
